apb_master_bridge: RTL and testbench

Single-initiator APB master that turns a buffered valid/ready command stream into AMBA 3 APB transfers. It returns one response per command, carrying read data and error status. It sits between a host-side sequencer (RISC-V side bus adapter or testbench driver) and the DRRA subsystem's APB slave interface. Typical use: loading instructions, filling the input buffer, writing control registers, and polling the return/status registers.

---
 rtl/apb_master_bridge_if.sv | 43 ++++
 rtl/apb_master_bridge.sv | 150 +++++++++++++++
 tb/tb_apb_master_bridge.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_bridge_if.sv
// rtl/apb_master_bridge_if.sv - command/response stream and APB bus bundle for apb_master_bridge
interface apb_master_bridge_if #(
    parameter int APB_AW = 32,
    parameter int APB_DW = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [APB_AW-1:0] cmd_addr;
    logic [APB_DW-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [APB_DW-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              busy;

    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [APB_AW-1:0] PADDR;
    logic [APB_DW-1:0] PWDATA;
    logic [APB_DW-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    // Bridge side
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    // Host sequencer plus APB slave side
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - buffered command stream to AMBA 3 APB master, one response per command
// Optional ACCESS timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
    parameter int APB_AW         = 32,
    parameter int APB_DW         = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    apb_master_bridge_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t state, state_nxt;

    logic              fifo_write [FIFO_DEPTH];
    logic [APB_AW-1:0] fifo_addr  [FIFO_DEPTH];
    logic [APB_DW-1:0] fifo_wdata [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       count;
    logic              full, empty, push, pop;

    logic              pwrite_q;
    logic [APB_AW-1:0] paddr_q;
    logic [APB_DW-1:0] pwdata_q;
    logic [APB_DW-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic              tmo_hit;

    assign full  = (count == (PW+1)'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign push  = bus.cmd_valid && !full;
    // A pop always coincides with entry to SETUP
    assign pop   = !empty && ((state == IDLE) || (state == RESP && bus.rsp_ready));

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_write[wr_ptr] <= bus.cmd_write;
            fifo_addr[wr_ptr]  <= bus.cmd_addr;
            fifo_wdata[wr_ptr] <= bus.cmd_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TW-1:0] tmo_cnt;
    logic          rsp_tmo_q;

    // Fires on the TIMEOUT_CYCLES-th stalled ACCESS cycle; PREADY=1 wins
    assign tmo_hit = (state == ACCESS) && !bus.PREADY && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt   <= '0;
            rsp_tmo_q <= 1'b0;
        end else begin
            if (pop)
                tmo_cnt <= '0;
            else if (state == ACCESS && !bus.PREADY)
                tmo_cnt <= tmo_cnt + 1'b1;
            if (state == ACCESS && (bus.PREADY || tmo_hit))
                rsp_tmo_q <= !bus.PREADY;
        end
    end

    assign bus.rsp_timeout = rsp_tmo_q;
`else
    assign tmo_hit         = 1'b0;
    assign bus.rsp_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pop) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (bus.PREADY || tmo_hit) state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = pop ? SETUP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.PSEL      = (state == SETUP) || (state == ACCESS);
        bus.PENABLE   = (state == ACCESS);
        bus.rsp_valid = (state == RESP);
        bus.busy      = !empty || (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
        end else if (pop) begin
            pwrite_q <= fifo_write[rd_ptr];
            paddr_q  <= fifo_addr[rd_ptr];
            pwdata_q <= fifo_wdata[rd_ptr];
        end
    end

    // Read data is only meaningful for a clean read; everything else reports zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else if (state == ACCESS) begin
            if (bus.PREADY) begin
                rsp_rdata_q <= (!pwrite_q && !bus.PSLVERR) ? bus.PRDATA : '0;
                rsp_err_q   <= bus.PSLVERR;
            end else if (tmo_hit) begin
                rsp_rdata_q <= '0;
                rsp_err_q   <= 1'b1;
            end
        end
    end

    assign bus.cmd_ready = !full;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - directed vector bench for apb_master_bridge
module tb_apb_master_bridge;
    logic clk;
    logic rst_n;

    apb_master_bridge_if #(.APB_AW(32), .APB_DW(32)) bus ();

    apb_master_bridge #(
        .APB_AW(32), .APB_DW(32), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          wait_n;
        logic        slverr;
        logic [31:0] prdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_psel;
    } vec_t;

    int n_total = 0;
    int n_pass  = 0;

    int          cfg_wait  = 0;
    logic        cfg_err   = 1'b0;
    logic [31:0] cfg_rdata = 32'h0;
    bit          cfg_xor   = 1'b0;
    int          acc_n     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // APB slave: stalls cfg_wait ACCESS cycles, then completes
    always @(posedge clk) begin
        #1;
        if (bus.PSEL && bus.PENABLE) begin
            bus.PREADY  = (acc_n >= cfg_wait);
            bus.PSLVERR = cfg_err && (acc_n >= cfg_wait);
            bus.PRDATA  = cfg_xor ? (bus.PADDR ^ 32'hFFFF_0000) : cfg_rdata;
            acc_n++;
        end else begin
            acc_n       = 0;
            bus.PREADY  = 1'b0;
            bus.PSLVERR = 1'b0;
            bus.PRDATA  = 32'h0;
        end
    end

    task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           output int lat, output int psel_n, output int pen_n, output int bad_hold);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        lat = 0; psel_n = 0; pen_n = 0; bad_hold = 0;
        while (!bus.rsp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (bus.PSEL) begin
                psel_n++;
                if (bus.PADDR !== addr || bus.PWRITE !== wr || (wr && bus.PWDATA !== wdata))
                    bad_hold++;
            end
            if (bus.PENABLE) pen_n++;
        end
    endtask

    task automatic consume();
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    vec_t        vecs [5];
    logic [31:0] exp_drain [5];

    initial begin
        int lat, psel_n, pen_n, bad_hold, guard, n_rsp, last_c, n_psel, n_rv;

        vecs[0] = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 0, 1'b0, 32'h0000_0055, 32'h0,          1'b0, 3, 2};
        vecs[1] = '{1'b0, 32'h0000_0408, 32'h0,         3, 1'b0, 32'h8000_0001, 32'h8000_0001, 1'b0, 6, 5};
        vecs[2] = '{1'b0, 32'h0000_0010, 32'h0,         0, 1'b1, 32'h0000_1234, 32'h0,          1'b1, 3, 2};
        vecs[3] = '{1'b0, 32'h0000_0014, 32'h0,         0, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 3, 2};
        vecs[4] = '{1'b1, 32'h0000_0020, 32'h1357_9BDF, 1, 1'b1, 32'hFFFF_FFFF, 32'h0,          1'b1, 4, 3};
        exp_drain = '{32'hFFFF_0100, 32'hFFFF_0104, 32'hFFFF_0108, 32'hFFFF_010C, 32'hFFFF_0110};

        rst_n = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready",   32'(bus.cmd_ready),   32'd1);
        check("rst_rsp_valid",   32'(bus.rsp_valid),   32'd0);
        check("rst_rsp_rdata",   bus.rsp_rdata,        32'd0);
        check("rst_rsp_err",     32'(bus.rsp_err),     32'd0);
        check("rst_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
        check("rst_busy",        32'(bus.busy),        32'd0);
        check("rst_psel",        32'(bus.PSEL),        32'd0);
        check("rst_penable",     32'(bus.PENABLE),     32'd0);
        check("rst_pwrite",      32'(bus.PWRITE),      32'd0);
        check("rst_paddr",       bus.PADDR,            32'd0);
        check("rst_pwdata",      bus.PWDATA,           32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 5; v++) begin
            cfg_wait = vecs[v].wait_n; cfg_err = vecs[v].slverr;
            cfg_rdata = vecs[v].prdata; cfg_xor = 1'b0;
            do_xfer(vecs[v].wr, vecs[v].addr, vecs[v].wdata, lat, psel_n, pen_n, bad_hold);
            check($sformatf("v%0d_latency", v), 32'(lat),    32'(vecs[v].exp_lat));
            check($sformatf("v%0d_psel_cyc", v), 32'(psel_n), 32'(vecs[v].exp_psel));
            check($sformatf("v%0d_pen_cyc", v),  32'(pen_n),  32'(vecs[v].exp_psel - 1));
            check($sformatf("v%0d_apb_hold", v), 32'(bad_hold), 32'd0);
            check($sformatf("v%0d_rdata", v),    bus.rsp_rdata, vecs[v].exp_rdata);
            check($sformatf("v%0d_err", v),      32'(bus.rsp_err), 32'(vecs[v].exp_err));
            check($sformatf("v%0d_timeout", v),  32'(bus.rsp_timeout), 32'd0);
            consume();
            check($sformatf("v%0d_rsp_drop", v), 32'(bus.rsp_valid), 32'd0);
        end
        check("idle_paddr_hold", bus.PADDR, 32'h0000_0020);
        check("idle_busy",       32'(bus.busy), 32'd0);

        // Fill: one in flight plus four queued, then backpressure
        cfg_wait = 0; cfg_err = 1'b0; cfg_xor = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0;
            bus.cmd_addr = 32'h100 + 32'(4 * i); bus.cmd_wdata = '0;
            guard = 0;
            while (!bus.cmd_ready && guard < 20) begin @(posedge clk); #1; guard++; end
            check($sformatf("fill%0d_ready", i), 32'(guard), 32'd0);
            @(posedge clk); #1;
        end
        bus.cmd_valid = 1'b0;
        check("full_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("full_busy",      32'(bus.busy),      32'd1);
        bus.cmd_valid = 1'b1; bus.cmd_addr = 32'h200;
        repeat (2) begin @(posedge clk); #1; end
        check("full_blocked", 32'(bus.cmd_ready), 32'd0);
        bus.cmd_valid = 1'b0;

        bus.rsp_ready = 1'b1;
        n_rsp = 0; last_c = 0;
        for (int c = 0; c < 60; c++) begin
            if (bus.rsp_valid) begin
                if (n_rsp < 5) check($sformatf("drain%0d_rdata", n_rsp), bus.rsp_rdata, exp_drain[n_rsp]);
                if (n_rsp > 0) check($sformatf("drain%0d_gap", n_rsp), 32'(c - last_c), 32'd3);
                last_c = c;
                n_rsp++;
            end
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b0;
        check("drain_count",     32'(n_rsp),         32'd5);
        check("drain_busy",      32'(bus.busy),      32'd0);
        check("drain_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // Reset during ACCESS with two commands queued
        cfg_xor = 1'b0; cfg_wait = 1000;
        for (int i = 0; i < 3; i++) begin
            bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1;
            bus.cmd_addr = 32'h300 + 32'(4 * i); bus.cmd_wdata = 32'(i);
            @(posedge clk); #1;
        end
        bus.cmd_valid = 1'b0;
        check("pre_rst_penable", 32'(bus.PENABLE), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_psel",      32'(bus.PSEL),      32'd0);
        check("mid_rst_penable",   32'(bus.PENABLE),   32'd0);
        check("mid_rst_busy",      32'(bus.busy),      32'd0);
        check("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1; cfg_wait = 0; bus.rsp_ready = 1'b1;
        n_psel = 0; n_rv = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (bus.PSEL) n_psel++;
            if (bus.rsp_valid) n_rv++;
        end
        bus.rsp_ready = 1'b0;
        check("post_rst_psel_cyc", 32'(n_psel), 32'd0);
        check("post_rst_rsp_cnt",  32'(n_rv),   32'd0);
        check("post_rst_busy",     32'(bus.busy), 32'd0);

`ifdef APB_MASTER_TIMEOUT_EN
        cfg_wait = 1000; cfg_err = 1'b0; cfg_rdata = 32'h5A5A_5A5A;
        do_xfer(1'b0, 32'h0000_0030, 32'h0, lat, psel_n, pen_n, bad_hold);
        check("tmo_latency", 32'(lat),    32'd10);
        check("tmo_psel",    32'(psel_n), 32'd9);
        check("tmo_pen",     32'(pen_n),  32'd8);
        check("tmo_err",     32'(bus.rsp_err),     32'd1);
        check("tmo_flag",    32'(bus.rsp_timeout), 32'd1);
        check("tmo_rdata",   bus.rsp_rdata,        32'd0);
        consume();
        cfg_wait = 0; cfg_rdata = 32'h0BAD_F00D;
        do_xfer(1'b0, 32'h0000_0034, 32'h0, lat, psel_n, pen_n, bad_hold);
        check("tmo_next_rdata", bus.rsp_rdata, 32'h0BAD_F00D);
        check("tmo_next_flag",  32'(bus.rsp_timeout), 32'd0);
        consume();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
